// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler slice.
package uart_pkg;

   typedef enum logic [1:0] {SCH_IDLE, SCH_LAUNCH, SCH_WAIT, SCH_GAP} sched_state_e;

   // Advance a round-robin pointer, wrapping explicitly for non-power-of-2 counts.
   function automatic int rr_next(input int ptr, input int num_req);
      return (ptr + 1 >= num_req) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [IDX_W-1:0]   idx,
   output logic [NUM_REQ-1:0] onehot
);

   // One spare bit so ptr+k never overflows before the modulo fold.
   localparam int SW = IDX_W + 1;

   logic [SW-1:0] slot;

   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      slot   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         slot = {1'b0, ptr} + SW'(k);
         if (slot >= SW'(NUM_REQ)) slot = slot - SW'(NUM_REQ);
         if (!any && req[slot[IDX_W-1:0]]) begin
            any                       = 1'b1;
            idx                       = slot[IDX_W-1:0];
            onehot[slot[IDX_W-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources,
// with post-frame idle gap and a tx_done watchdog.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_BITS      = 8,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             req_done,
   output logic                           tx_start,
   output logic [DATA_BITS-1:0]           tx_data,
   input  logic                           tx_done,
   output logic                           busy,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           timeout_err
);

   localparam int IW  = $clog2(NUM_REQ);
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam sched_state_e POST_FRAME = (GAP_CYCLES > 0) ? SCH_GAP : SCH_IDLE;

   sched_state_e         state_q, state_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]        grant_id_q, grant_id_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic [WDW-1:0]       wd_cnt_q, wd_cnt_d;
   logic [GCW-1:0]       gap_cnt_q, gap_cnt_d;
   logic                 tx_start_q, tx_start_d;

   logic                 pick_any;
   logic [IW-1:0]        pick_idx;
   logic [NUM_REQ-1:0]   pick_onehot;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IW)
   ) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      hold_d      = hold_q;
      wd_cnt_d    = wd_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      tx_start_d  = 1'b0;
      req_ready   = '0;
      req_done    = '0;
      timeout_err = 1'b0;

      case (state_q)
         SCH_IDLE: begin
            if (pick_any) begin
               req_ready  = pick_onehot;
               grant_id_d = pick_idx;
               tx_start_d = 1'b1;
               state_d    = SCH_LAUNCH;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (pick_onehot[i]) hold_d = req_data[i*DATA_BITS +: DATA_BITS];
               end
            end
         end
         SCH_LAUNCH: begin
            wd_cnt_d = '0;
            state_d  = SCH_WAIT;
         end
         SCH_WAIT: begin
            wd_cnt_d = wd_cnt_q + WDW'(1);
            // Completion is checked first so it wins a tie with watchdog expiry.
            if (tx_done) begin
               req_done[grant_id_q] = 1'b1;
               rr_ptr_d             = IW'(rr_next(int'(grant_id_q), NUM_REQ));
               gap_cnt_d            = '0;
               state_d              = POST_FRAME;
            end else if (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 1)) begin
               timeout_err = 1'b1;
               rr_ptr_d    = IW'(rr_next(int'(grant_id_q), NUM_REQ));
               gap_cnt_d   = '0;
               state_d     = POST_FRAME;
            end
         end
         SCH_GAP: begin
            if (gap_cnt_q == GCW'(GAP_CYCLES - 1)) state_d = SCH_IDLE;
            else gap_cnt_d = gap_cnt_q + GCW'(1);
         end
         default: state_d = SCH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SCH_IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         hold_q     <= '0;
         wd_cnt_q   <= '0;
         gap_cnt_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         hold_q     <= hold_d;
         wd_cnt_q   <= wd_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = hold_q;
   assign busy     = (state_q != SCH_IDLE);
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a scoreboard of expected launches.
module tb_uart_tx_sched;

   localparam int NR   = 4;
   localparam int DB   = 8;
   localparam int GAP  = 2;
   localparam int TO   = 40;
   localparam int XLAT = 20;

   localparam int W_START = 0;
   localparam int W_DONE  = 1;
   localparam int W_IDLE  = 2;
   localparam int W_TO    = 3;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] b;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NR-1:0] req_valid = '0;
   logic [NR*DB-1:0] req_data = '0;
   logic          tx_done = 1'b0;
   logic [NR-1:0] req_ready;
   logic [NR-1:0] req_done;
   logic          tx_start;
   logic [DB-1:0] tx_data;
   logic          busy;
   logic [1:0]    grant_id;
   logic          timeout_err;

   always #5 clk = ~clk;

   uart_tx_sched #(
      .NUM_REQ        (NR),
      .DATA_BITS      (DB),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .req_done    (req_done),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;
   int cd = 0;
   int cur_id = 0;
   int last_start = 0, last_done = 0, last_ready = 0, last_to = 0;
   int done_cnt = 0, to_cnt = 0;
   logic [NR-1:0]    nrv = '0;
   logic [NR*DB-1:0] nrd = '0;
   logic nrst = 1'b1;
   bit   keep = 1'b0;
   bit   xm_en = 1'b1;
   bit   force_done = 1'b0;
   exp_t exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int id, input logic [7:0] b);
      exp_t e;
      e.id = 2'(id);
      e.b  = b;
      exp_q.push_back(e);
   endtask

   task automatic set_byte(input int i, input logic [7:0] b);
      nrd[i*DB +: DB] = b;
   endtask

   // One clock: apply pending inputs, run the transmitter model, then monitor.
   task automatic cyc();
      exp_t e;
      @(posedge clk);
      #1;
      rst       = nrst;
      req_valid = nrv;
      req_data  = nrd;
      tx_done   = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0 && xm_en) tx_done = 1'b1;
      end
      if (force_done) tx_done = 1'b1;
      #1;
      cyc_no++;
      if (req_ready != '0) begin
         last_ready = cyc_no;
         if (!keep) nrv = nrv & ~req_ready;
      end
      if (tx_start) begin
         cd = XLAT;
         last_start = cyc_no;
         chk("sb_start_expected", (exp_q.size() != 0) ? 1 : 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cur_id = int'(e.id);
            chk("sb_tx_data", tx_data, e.b);
            chk("sb_grant_id", grant_id, e.id);
         end
      end
      if (req_done != '0) begin
         done_cnt++;
         last_done = cyc_no;
         chk("sb_req_done", req_done, 4'b0001 << cur_id);
      end
      if (timeout_err) begin
         to_cnt++;
         last_to = cyc_no;
      end
   endtask

   function automatic logic cond(input int sel);
      case (sel)
         W_START: return tx_start;
         W_DONE:  return req_done != '0;
         W_IDLE:  return !busy;
         default: return timeout_err;
      endcase
   endfunction

   task automatic wait_for(input int sel, input string tag, input int budget);
      int n = 0;
      do begin
         cyc();
         n++;
      end while (!cond(sel) && n < budget);
      chk(tag, cond(sel), 1'b1);
   endtask

   task automatic do_reset();
      nrv  = '0;
      keep = 1'b0;
      nrst = 1'b1;
      cyc();
      cyc();
      nrst = 1'b0;
      cyc();
      exp_q.delete();
      cd = 0;
   endtask

   initial begin
      #50000;
      $display("FAIL sim_timeout observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int t0, d0, to0, prev;

      // Reset state
      cyc();
      cyc();
      chk("rst_busy", busy, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_req_done", req_done, 0);
      chk("rst_timeout", timeout_err, 0);
      nrst = 1'b0;
      cyc();

      // 1: single request from requester 2
      set_byte(2, 8'hA5);
      push(2, 8'hA5);
      nrv = 4'b0100;
      cyc();
      chk("t1_ready", req_ready, 4'b0100);
      cyc();
      chk("t1_start", tx_start, 1);
      chk("t1_busy", busy, 1);
      t0 = cyc_no;
      wait_for(W_DONE, "t1_done_seen", 40);
      chk("t1_done_lat", cyc_no - t0, XLAT);
      chk("t1_done_vec", req_done, 4'b0100);
      cyc();
      chk("t1_busy_gap1", busy, 1);
      cyc();
      chk("t1_busy_gap2", busy, 1);
      cyc();
      chk("t1_idle_after3", busy, 0);
      chk("t1_grant_id", grant_id, 2);

      // 2: all four requesting continuously
      do_reset();
      for (int i = 0; i < NR; i++) set_byte(i, 8'h10 + 8'(i));
      push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
      keep = 1'b1;
      nrv  = 4'b1111;
      prev = 0;
      for (int f = 0; f < 5; f++) begin
         wait_for(W_START, "t2_start", 40);
         if (f > 0) begin
            chk("t2_start_spacing", last_start - prev, 24);
            chk("t2_done_to_ready", last_ready - last_done, 3);
         end
         prev = last_start;
      end
      keep = 1'b0;
      nrv  = '0;
      wait_for(W_DONE, "t2_last_done", 40);
      wait_for(W_IDLE, "t2_idle", 10);

      // 3: fairness after wrap
      do_reset();
      set_byte(3, 8'h33);
      set_byte(0, 8'h30);
      push(3, 8'h33);
      nrv = 4'b1000;
      wait_for(W_START, "t3_start_first", 10);
      push(0, 8'h30);
      push(3, 8'h33);
      nrv = 4'b1001;
      wait_for(W_START, "t3_start_second", 40);
      wait_for(W_START, "t3_start_third", 40);
      wait_for(W_DONE, "t3_done", 40);
      wait_for(W_IDLE, "t3_idle", 10);

      // 4: watchdog abort, then pointer moves past the aborted owner
      set_byte(1, 8'h44);
      push(1, 8'h44);
      xm_en = 1'b0;
      nrv   = 4'b0010;
      wait_for(W_START, "t4_start", 10);
      t0 = last_start;
      d0 = done_cnt;
      wait_for(W_TO, "t4_timeout_seen", 60);
      chk("t4_timeout_lat", last_to - t0, TO);
      chk("t4_no_req_done", done_cnt, d0);
      cyc();
      chk("t4_timeout_single", timeout_err, 0);
      chk("t4_busy_gap", busy, 1);
      xm_en = 1'b1;
      set_byte(1, 8'h41);
      set_byte(2, 8'h52);
      push(2, 8'h52);
      push(1, 8'h41);
      nrv = 4'b0110;
      wait_for(W_START, "t4_next_a", 20);
      wait_for(W_START, "t4_next_b", 40);
      wait_for(W_DONE, "t4_done", 40);
      wait_for(W_IDLE, "t4_idle", 10);

      // 5: completion on the watchdog-expiry cycle, then spurious tx_done in IDLE
      set_byte(0, 8'h5A);
      push(0, 8'h5A);
      xm_en = 1'b0;
      nrv   = 4'b0001;
      wait_for(W_START, "t5_start", 10);
      repeat (TO - 1) cyc();
      force_done = 1'b1;
      cyc();
      force_done = 1'b0;
      chk("t5_race_done", req_done, 4'b0001);
      chk("t5_race_no_timeout", timeout_err, 0);
      wait_for(W_IDLE, "t5_idle", 10);
      cyc();
      to0 = to_cnt;
      force_done = 1'b1;
      cyc();
      force_done = 1'b0;
      chk("t5_spur_busy", busy, 0);
      chk("t5_spur_start", tx_start, 0);
      chk("t5_spur_done", req_done, 0);
      chk("t5_spur_timeout", timeout_err, 0);
      chk("t5_spur_ready", req_ready, 0);
      cyc();
      chk("t5_spur_busy_after", busy, 0);
      chk("t5_spur_grant", grant_id, 0);
      chk("t5_spur_tx_data", tx_data, 8'h5A);
      chk("t5_no_late_timeout", to_cnt, to0);
      xm_en = 1'b1;

      // 6: reset during WAIT
      set_byte(2, 8'h66);
      push(2, 8'h66);
      nrv = 4'b0100;
      wait_for(W_START, "t6_start", 10);
      repeat (5) cyc();
      d0 = done_cnt;
      nrst = 1'b1;
      cyc();
      nrst = 1'b0;
      cyc();
      chk("t6_busy", busy, 0);
      chk("t6_tx_start", tx_start, 0);
      chk("t6_tx_data", tx_data, 0);
      chk("t6_grant_id", grant_id, 0);
      chk("t6_req_done", req_done, 0);
      chk("t6_timeout", timeout_err, 0);
      chk("t6_req_ready", req_ready, 0);
      chk("t6_no_done_pulse", done_cnt, d0);
      set_byte(0, 8'h70);
      set_byte(1, 8'h71);
      push(0, 8'h70);
      push(1, 8'h71);
      nrv = 4'b0011;
      wait_for(W_START, "t6_post_a", 10);
      wait_for(W_START, "t6_post_b", 40);
      wait_for(W_DONE, "t6_done", 40);
      wait_for(W_IDLE, "t6_idle", 10);

      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
